// File: rtl/counter_csr_port.sv
// ---------------------------------------------------------------------------
// counter_csr_port
//   CSR-side access port for the 64-bit machine counters (cycle, instret) on
//   an RV32 datapath. A request is handled by a fixed four-state sequence.
//   IDLE latches the request. READ captures the old CSR half and decodes
//   legality. WRITE computes the new value and pulses the counter load strobe.
//   RESP returns the old value with a one-cycle ack.
//   The module also holds mcountinhibit. Only bits 0 (cycle) and 2 (instret)
//   are implemented.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_req/addr/op/wdata      request from the core (req held until ack)
//   csr_ack/rdata/illegal      one-cycle response
//   cycle_in, instret_in       live counter values
//   cycle_load_en/data         load strobe and value for the cycle counter
//   instret_load_en/data       load strobe and value for the instret counter
//   cy_inhibit, ir_inhibit     mcountinhibit[0], mcountinhibit[2]
//
// COUNT_LEN must equal 2*XLEN.
// ---------------------------------------------------------------------------
module counter_csr_port #(
  parameter int COUNT_LEN = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_req,
  input  logic [11:0]          csr_addr,
  input  logic [1:0]           csr_op,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic                 csr_ack,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_illegal,
  input  logic [COUNT_LEN-1:0] cycle_in,
  input  logic [COUNT_LEN-1:0] instret_in,
  output logic                 cycle_load_en,
  output logic [COUNT_LEN-1:0] cycle_load_data,
  output logic                 instret_load_en,
  output logic [COUNT_LEN-1:0] instret_load_data,
  output logic                 cy_inhibit,
  output logic                 ir_inhibit
);

  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MCOUNTINH = 12'h320;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [11:0]            addr_reg;
  logic [1:0]             op_reg;
  logic [XLEN-1:0]        wdata_reg;
  logic [XLEN-1:0]        old_q;
  logic                   illegal_reg;
  logic                   cy_inh_reg;
  logic                   ir_inh_reg;
  logic [COUNT_LEN-1:0]   cycle_data_reg;
  logic [COUNT_LEN-1:0]   instret_data_reg;

  logic [XLEN-1:0]        inh_val;
  logic [XLEN-1:0]        read_val;
  logic [XLEN-1:0]        new_val;
  logic                   wants_write;
  logic                   is_counter_rw;
  logic                   is_shadow;
  logic                   is_inh;
  logic                   legal;
  logic                   do_write;
  logic                   cycle_hit;
  logic                   instret_hit;
  logic [COUNT_LEN-1:0]   cycle_next;
  logic [COUNT_LEN-1:0]   instret_next;

  // -------------------------------------------------------------------------
  // FSM: state register plus next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (csr_req) state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // mcountinhibit read view: bit 0 = cycle, bit 2 = instret, all others zero.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_inh_bits
      if (gi == 0) begin : g_cy
        assign inh_val[gi] = cy_inh_reg;
      end else if (gi == 2) begin : g_ir
        assign inh_val[gi] = ir_inh_reg;
      end else begin : g_zero
        assign inh_val[gi] = 1'b0;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Decode of the latched request
  // -------------------------------------------------------------------------
  // RS/RC with a zero operand is a pure read, so a user-mode shadow access of
  // that form is legal.
  assign wants_write = (op_reg == OP_RW) ||
                       ((op_reg == OP_RS || op_reg == OP_RC) && (wdata_reg != '0));

  assign is_counter_rw = (addr_reg == ADDR_MCYCLE)   || (addr_reg == ADDR_MCYCLEH) ||
                         (addr_reg == ADDR_MINSTRET) || (addr_reg == ADDR_MINSTRETH);
  assign is_shadow     = (addr_reg == ADDR_CYCLE)    || (addr_reg == ADDR_CYCLEH) ||
                         (addr_reg == ADDR_INSTRET)  || (addr_reg == ADDR_INSTRETH);
  assign is_inh        = (addr_reg == ADDR_MCOUNTINH);
  assign legal         = is_counter_rw || is_inh || (is_shadow && !wants_write);

  always_comb begin
    read_val = '0;
    case (addr_reg)
      ADDR_MCYCLE,    ADDR_CYCLE:    read_val = cycle_in[XLEN-1:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   read_val = cycle_in[COUNT_LEN-1:XLEN];
      ADDR_MINSTRET,  ADDR_INSTRET:  read_val = instret_in[XLEN-1:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: read_val = instret_in[COUNT_LEN-1:XLEN];
      ADDR_MCOUNTINH:                read_val = inh_val;
      default:                       read_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_q;
    case (op_reg)
      OP_RW:   new_val = wdata_reg;
      OP_RS:   new_val = old_q | wdata_reg;
      OP_RC:   new_val = old_q & ~wdata_reg;
      default: new_val = old_q;
    endcase
  end

  // An illegal access never writes. Shadows with a real write are illegal, so
  // only the read/write addresses can reach a strobe here.
  assign do_write    = (state_reg == WRITE) && wants_write && !illegal_reg;
  assign cycle_hit   = (addr_reg == ADDR_MCYCLE)   || (addr_reg == ADDR_MCYCLEH);
  assign instret_hit = (addr_reg == ADDR_MINSTRET) || (addr_reg == ADDR_MINSTRETH);

  // The untouched half comes from the live counter in the WRITE cycle itself.
  assign cycle_next   = (addr_reg == ADDR_MCYCLEH) ?
                        {new_val, cycle_in[XLEN-1:0]} :
                        {cycle_in[COUNT_LEN-1:XLEN], new_val};
  assign instret_next = (addr_reg == ADDR_MINSTRETH) ?
                        {new_val, instret_in[XLEN-1:0]} :
                        {instret_in[COUNT_LEN-1:XLEN], new_val};

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg         <= '0;
      op_reg           <= '0;
      wdata_reg        <= '0;
      old_q            <= '0;
      illegal_reg      <= 1'b0;
      cy_inh_reg       <= 1'b0;
      ir_inh_reg       <= 1'b0;
      cycle_data_reg   <= '0;
      instret_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (csr_req) begin
            addr_reg  <= csr_addr;
            op_reg    <= csr_op;
            wdata_reg <= csr_wdata;
          end
        end
        READ: begin
          old_q       <= read_val;
          illegal_reg <= !legal;
        end
        WRITE: begin
          if (cycle_load_en)   cycle_data_reg   <= cycle_next;
          if (instret_load_en) instret_data_reg <= instret_next;
          if (do_write && is_inh) begin
            cy_inh_reg <= new_val[0];
            ir_inh_reg <= new_val[2];
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cycle_load_en   = do_write && cycle_hit;
  assign instret_load_en = do_write && instret_hit;

  // The load value shows during the strobe cycle and is held afterwards.
  assign cycle_load_data   = cycle_load_en   ? cycle_next   : cycle_data_reg;
  assign instret_load_data = instret_load_en ? instret_next : instret_data_reg;

  assign csr_ack     = (state_reg == RESP);
  assign csr_illegal = (state_reg == RESP) && illegal_reg;
  assign csr_rdata   = ((state_reg == RESP) && !illegal_reg) ? old_q : '0;

  assign cy_inhibit = cy_inh_reg;
  assign ir_inhibit = ir_inh_reg;

endmodule

// File: tb/tb_counter_csr_port.sv
// ---------------------------------------------------------------------------
// tb_counter_csr_port
//   Self-checking bench for counter_csr_port. It runs directed cases for
//   reset, reads, writes, set/clear, inhibit and illegal access. It then runs
//   randomized transactions. The reference model works per transaction on
//   the CSR semantics: the selected counter half, the new value from the op,
//   and the legality rules.
// ---------------------------------------------------------------------------
module tb_counter_csr_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [63:0] cycle_in;
  logic [63:0] instret_in;
  logic        cycle_load_en;
  logic [63:0] cycle_load_data;
  logic        instret_load_en;
  logic [63:0] instret_load_data;
  logic        cy_inhibit;
  logic        ir_inhibit;

  always #5 clk = ~clk;

  counter_csr_port #(.COUNT_LEN(64), .XLEN(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .csr_req           (csr_req),
    .csr_addr          (csr_addr),
    .csr_op            (csr_op),
    .csr_wdata         (csr_wdata),
    .csr_ack           (csr_ack),
    .csr_rdata         (csr_rdata),
    .csr_illegal       (csr_illegal),
    .cycle_in          (cycle_in),
    .instret_in        (instret_in),
    .cycle_load_en     (cycle_load_en),
    .cycle_load_data   (cycle_load_data),
    .instret_load_en   (instret_load_en),
    .instret_load_data (instret_load_data),
    .cy_inhibit        (cy_inhibit),
    .ir_inhibit        (ir_inhibit)
  );

  int vectors     = 0;
  int miscompares = 0;
  int txn_count   = 0;

  // Reference state
  logic [31:0] model_inh;      // mcountinhibit value, only bits 0 and 2 live
  logic [63:0] model_cyc_ld;   // last cycle load value
  logic [63:0] model_ir_ld;    // last instret load value

  logic [11:0] addr_tab [9] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction. Call it at a negedge with the DUT idle; it returns
  // at a negedge with the DUT idle again. rc/ri are the live counters in the
  // READ cycle, and wc/wi are the live counters in the WRITE cycle.
  task automatic run_txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         input logic [63:0] rc, input logic [63:0] ri,
                         input logic [63:0] wc, input logic [63:0] wi);
    bit          is_rw, is_sh, is_inh, eff, legal;
    logic [63:0] ctr;
    logic [31:0] old, nv;
    logic        exp_cyc_en, exp_ir_en;

    // Reference expectations from the CSR rules
    is_rw  = (a[11:8] == 4'hB) && (a[6:0] == 7'h00 || a[6:0] == 7'h02) && (a[7] == a[7]);
    is_rw  = is_rw && (a[5:2] == 4'h0);
    is_sh  = (a[11:8] == 4'hC) && (a[6:0] == 7'h00 || a[6:0] == 7'h02);
    is_inh = (a == 12'h320);
    eff    = (op == 2'b01) || (op[1] && wd != 0);
    legal  = is_rw || is_inh || (is_sh && !eff);

    // Address bit 1 selects instret, and bit 7 selects the high half.
    ctr = a[1] ? ri : rc;
    if (is_inh)              old = model_inh;
    else if (is_rw || is_sh) old = a[7] ? ctr[63:32] : ctr[31:0];
    else                     old = 0;

    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      2'b11:   nv = old & ~wd;
      default: nv = old;
    endcase

    exp_cyc_en = legal && eff && is_rw && !a[1];
    exp_ir_en  = legal && eff && is_rw &&  a[1];
    if (exp_cyc_en) model_cyc_ld = a[7] ? {nv, wc[31:0]} : {wc[63:32], nv};
    if (exp_ir_en)  model_ir_ld  = a[7] ? {nv, wi[31:0]} : {wi[63:32], nv};

    // IDLE cycle: present the request
    csr_req = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
    cycle_in = rnd64(); instret_in = rnd64();
    @(posedge clk); @(negedge clk);
    // READ cycle
    csr_req = 1'b0; csr_addr = $urandom; csr_op = 2'($urandom); csr_wdata = $urandom;
    cycle_in = rc; instret_in = ri;
    #1;
    check_val("read_ack", csr_ack, 0);
    check_val("read_ld", {cycle_load_en, instret_load_en}, 0);
    @(posedge clk); @(negedge clk);
    // WRITE cycle
    cycle_in = wc; instret_in = wi;
    #1;
    check_val("ack_early", csr_ack, 0);
    check_val("cyc_ld_en", cycle_load_en, exp_cyc_en);
    check_val("ir_ld_en", instret_load_en, exp_ir_en);
    check_val("cyc_ld_data", cycle_load_data, model_cyc_ld);
    check_val("ir_ld_data", instret_load_data, model_ir_ld);
    @(posedge clk); @(negedge clk);
    // RESP cycle
    if (legal && eff && is_inh) model_inh = nv & 32'h5;
    cycle_in = rnd64(); instret_in = rnd64();
    #1;
    check_val("ack", csr_ack, 1);
    check_val("rdata", csr_rdata, legal ? old : 32'h0);
    check_val("illegal", csr_illegal, !legal);
    check_val("inhibit", {cy_inhibit, ir_inhibit}, {model_inh[0], model_inh[2]});
    check_val("resp_ld", {cycle_load_en, instret_load_en}, 0);
    txn_count++;
    $display("txn %0d addr=%h op=%0d wdata=%h rdata=%h illegal=%0d", txn_count, a, op, wd, csr_rdata, csr_illegal);
    @(posedge clk); @(negedge clk);
    #1;
    check_val("idle_ack", csr_ack, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] i0;
    logic [31:0] wd;
    int          gap;
    bit          seen;

    model_inh = 0; model_cyc_ld = 0; model_ir_ld = 0;

    // ---- Reset has priority over a pending RW request ----
    rst_n = 1'b0; csr_req = 1'b1; csr_addr = 12'hB02; csr_op = 2'b01;
    wd = 32'h1234_5678; csr_wdata = wd;
    i0 = 64'h0000_0009_0000_0042; cycle_in = rnd64(); instret_in = i0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_ack", csr_ack, 0);
    check_val("rst_ld", {cycle_load_en, instret_load_en}, 0);
    check_val("rst_ld_data", {cycle_load_data, instret_load_data}, 0);
    check_val("rst_outs", {csr_rdata, csr_illegal, cy_inhibit, ir_inhibit}, 0);
    // Release reset; the first edge afterwards samples the held request.
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check_val("rel_ack1", csr_ack, 0);
    @(posedge clk); @(negedge clk); #1;
    check_val("rel_ack2", csr_ack, 0);
    check_val("rel_ir_ld_en", instret_load_en, 1);
    check_val("rel_ir_ld_data", instret_load_data, {i0[63:32], wd});
    model_ir_ld = {i0[63:32], wd};
    @(posedge clk); @(negedge clk); #1;
    check_val("rel_ack3", csr_ack, 1);
    check_val("rel_rdata", csr_rdata, i0[31:0]);
    csr_req = 1'b0;
    @(posedge clk); @(negedge clk);

    // ---- Directed cases from the CSR rules ----
    i0 = 64'h0000_0005_0000_0076;
    run_txn(12'hB02, 2'b00, 32'h0, rnd64(), i0, rnd64(), i0);          // read minstret
    run_txn(12'hB82, 2'b00, 32'h0, rnd64(), i0, rnd64(), i0);          // read minstreth
    run_txn(12'hB02, 2'b01, 32'd12, rnd64(), i0, rnd64(), i0);         // write low half
    run_txn(12'hB80, 2'b10, 32'h0F, {32'hF0, 32'h1}, rnd64(), {32'hF0, 32'h2}, rnd64()); // RS
    run_txn(12'hB80, 2'b11, 32'h0, {32'hF0, 32'h1}, rnd64(), {32'hF0, 32'h2}, rnd64());  // RC mask 0
    run_txn(12'h320, 2'b01, 32'hFFFF_FFFF, rnd64(), rnd64(), rnd64(), rnd64());
    run_txn(12'h320, 2'b00, 32'h0, rnd64(), rnd64(), rnd64(), rnd64());
    run_txn(12'h320, 2'b11, 32'h1, rnd64(), rnd64(), rnd64(), rnd64());
    run_txn(12'hC02, 2'b01, 32'h1, rnd64(), rnd64(), rnd64(), rnd64());  // illegal write
    run_txn(12'h123, 2'b00, 32'h0, rnd64(), rnd64(), rnd64(), rnd64());  // unknown
    run_txn(12'hC80, 2'b10, 32'h0, rnd64(), rnd64(), rnd64(), rnd64());  // legal shadow read
    run_txn(12'hC00, 2'b00, 32'h0, rnd64(), rnd64(), rnd64(), rnd64());

    // ---- Back-to-back: req held high gives one ack every 4 cycles ----
    csr_req = 1'b1; csr_addr = 12'hC00; csr_op = 2'b00; csr_wdata = 0;
    gap = 0; seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk); #1;
      if (csr_ack) begin
        if (seen) check_val("b2b_gap", gap, 4);
        seen = 1; gap = 0;
      end
      gap++;
    end
    check_val("b2b_seen", seen, 1);
    csr_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    // ---- Reset in mid-transaction aborts the strobe and ack ----
    csr_req = 1'b1; csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    csr_req = 1'b0;
    rst_n = 1'b0; #1;
    check_val("abort_ld", {cycle_load_en, instret_load_en}, 0);
    check_val("abort_ack", csr_ack, 0);
    check_val("abort_ld_data", {cycle_load_data, instret_load_data}, 0);
    model_inh = 0; model_cyc_ld = 0; model_ir_ld = 0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check_val("abort_ld2", {cycle_load_en, instret_load_en, csr_ack}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Randomized transactions ----
    for (int n = 0; n < 200; n++) begin
      logic [11:0] a;
      logic [1:0]  op;
      logic [31:0] w;
      a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 8)];
      op = 2'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    w = 0;
        2:       w = 32'hFFFF_FFFF;
        default: w = $urandom;
      endcase
      run_txn(a, op, w, rnd64(), rnd64(), rnd64(), rnd64());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
